// File: rtl/ram_ctrl_pkg.sv
// Shared types and defaults for the RAM request controller.
package ram_ctrl_pkg;

    localparam int DEF_AW = 5;
    localparam int DEF_DW = 4;
    localparam int DEF_LW = 5;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_VFY
    } state_t;

endpackage

// File: rtl/ram_burst_addr_gen.sv
// Burst address generator: start address plus beat offset, wrapping at DEPTH.
module ram_burst_addr_gen
    import ram_ctrl_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int LW = DEF_LW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [AW-1:0] i_start,
    input  logic [LW-1:0] i_len,
    input  logic          i_step,
    output logic [AW-1:0] o_addr,
    output logic          o_last
);

    logic [AW-1:0] r_start;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_beat;
    logic [AW-1:0] w_off;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_start <= '0;
            r_len   <= '0;
            r_beat  <= '0;
        end else if (i_load) begin
            r_start <= i_start;
            r_len   <= i_len;
            r_beat  <= '0;
        end else if (i_step) begin
            r_beat  <= r_beat + 1'b1;
        end
    end

    // Natural AW-bit overflow gives the modulo-DEPTH wrap.
    assign w_off  = AW'(r_beat);
    assign o_addr = r_start + w_off;
    assign o_last = (r_beat == r_len);

endmodule

// File: rtl/ram_req_ctrl.sv
// RAM request controller: clears RAM after reset, then serves fill/burst-read.
// Optional write-verify pass enabled by defining WRITE_VERIFY_EN.
module ram_req_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW,
    parameter int LW = DEF_LW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [LW-1:0] req_len,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_last,
    output logic          init_done,
    output logic          busy,
    output logic          err,
    output logic          ram_we,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_di,
    input  logic [DW-1:0] ram_do
);

    localparam logic [AW-1:0] LAST_ADDR = '1;

    state_t        r_state;
    logic [AW-1:0] r_cnt;
    logic          r_init_done;
    logic [DW-1:0] r_wdata;
    logic          r_s1_valid;
    logic          r_s1_last;
    logic [DW-1:0] r_s1_data;
    logic          r_rsp_valid;
    logic          r_rsp_last;
    logic [DW-1:0] r_rsp_data;
    logic [AW-1:0] w_gen_addr;
    logic          w_gen_last;
    logic          w_load;
    logic          w_step;

    assign w_load = (r_state == ST_IDLE) && req_valid;

`ifdef WRITE_VERIFY_EN
    logic r_err;
    // A fill beat advances only after its verify cycle.
    assign w_step = !w_gen_last &&
                    (r_state == ST_RD || r_state == ST_VFY);
    assign err    = r_err;
`else
    assign w_step = !w_gen_last &&
                    (r_state == ST_RD || r_state == ST_WR);
    assign err    = 1'b0;
`endif

    ram_burst_addr_gen #(
        .AW (AW),
        .LW (LW)
    ) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_start (req_addr),
        .i_len   (req_len),
        .i_step  (w_step),
        .o_addr  (w_gen_addr),
        .o_last  (w_gen_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_wdata     <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_data   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_rsp_data  <= '0;
`ifdef WRITE_VERIFY_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_rsp_valid <= r_s1_valid;
            r_rsp_last  <= r_s1_last;
            if (r_s1_valid) begin
                r_rsp_data <= r_s1_data;
            end
            unique case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ADDR) begin
                        r_state     <= ST_IDLE;
                        r_init_done <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        r_wdata <= req_wdata;
                        r_state <= req_we ? ST_WR : ST_RD;
                    end
                end
                ST_WR: begin
`ifdef WRITE_VERIFY_EN
                    r_state <= ST_VFY;
`else
                    if (w_gen_last) begin
                        r_state <= ST_IDLE;
                    end
`endif
                end
                ST_RD: begin
                    r_s1_valid <= 1'b1;
                    r_s1_data  <= ram_do;
                    r_s1_last  <= w_gen_last;
                    if (w_gen_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_VFY: begin
`ifdef WRITE_VERIFY_EN
                    if (ram_do != r_wdata) begin
                        r_err <= 1'b1;
                    end
                    r_state <= w_gen_last ? ST_IDLE : ST_WR;
`else
                    r_state <= ST_IDLE;
`endif
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    always_comb begin
        ram_we = 1'b0;
        ram_a  = '0;
        ram_di = '0;
        unique case (r_state)
            ST_INIT: begin
                ram_we = 1'b1;
                ram_a  = r_cnt;
            end
            ST_WR: begin
                ram_we = 1'b1;
                ram_a  = w_gen_addr;
                ram_di = r_wdata;
            end
            ST_RD, ST_VFY: begin
                ram_a  = w_gen_addr;
            end
            default: ;
        endcase
    end

    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign init_done = r_init_done;
    assign rsp_valid = r_rsp_valid;
    assign rsp_last  = r_rsp_last;
    assign rsp_data  = r_rsp_data;

endmodule

// File: doc/ram_req_ctrl.md
Name: ram_req_ctrl

Overview:
- Initiator-side controller for the team's single-port, asynchronous-read inferred RAM (32x4 default: we, a, di, do).
- Clears the whole RAM after reset.
- Then serves fill-write and burst-read requests from a valid/ready request channel, driving the RAM port and returning read data on a response stream.
- Sits between a client block and the RAM instance; it is the only driver of the RAM port.

Parameters:
AW, 5, RAM address width; DEPTH = 2**AW
DW, 4, RAM data width
LW, 5, burst length field width (beats minus one)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept request
req_we  input  1  1 = fill-write, 0 = burst-read
req_addr  input  AW  start address
req_wdata  input  DW  fill data (writes only)
req_len  input  LW  beats minus one (0 = 1 beat)
rsp_valid  output  1  read beat valid (no backpressure)
rsp_data  output  DW  read beat data
rsp_last  output  1  final beat of burst, qualified by rsp_valid
init_done  output  1  RAM clear complete
busy  output  1  not IDLE
err  output  1  sticky verify mismatch (0 when feature compiled out)
ram_we  output  1  RAM write enable
ram_a  output  AW  RAM address
ram_di  output  DW  RAM write data
ram_do  input  DW  RAM asynchronous read data

Behaviour:
- Reset (rst_n=0 at a clk edge, synchronous): state=INIT, init counter=0. Outputs: req_ready=0, rsp_valid=0, rsp_data=0, rsp_last=0, init_done=0, err=0. Flops driving ram_we/ram_a/ram_di are cleared.
- RAM port outputs are combinational from state and counters.
- INIT:
  - ram_we=1, ram_a=cnt, ram_di=0, one address per cycle, for DEPTH cycles.
  - After the cycle with cnt=DEPTH-1: go to IDLE, init_done=1 (stays 1 until reset). busy=1.
- IDLE:
  - req_ready=1, ram_we=0, ram_a=0, busy=0.
  - Accept on req_valid&&req_ready at an edge: latch we, addr, wdata, len. Beat counter=0. Go to WR or RD.
- Address for beat i is (addr+i) mod DEPTH; wrap-around past DEPTH-1 to 0 is legal.
- WR:
  - Each cycle ram_we=1, ram_a=addr+i, ram_di=wdata.
  - After beat len: go to IDLE.
  - Total len+1 cycles; req_ready=0 throughout.
- RD:
  - Each cycle ram_we=0, ram_a=addr+i.
  - ram_do is sampled at that edge into rsp_data; rsp_valid=1 in the following cycle.
  - rsp_last=1 with the beat i==len.
  - After the last beat: go to IDLE.
  - Latency: accept at edge N, beat 0 data valid after edge N+2. Back-to-back responses, one per cycle.
- rsp_valid and rsp_last deassert the cycle after the final beat unless a new burst produces data.
- The next request is accepted in IDLE, so there is a minimum 1-cycle gap between bursts.
- A request presented during INIT or busy waits (req_ready=0); the client must hold req fields stable until accepted.
- Reset mid-burst or mid-INIT: abort at once, no further RAM writes or responses. The RAM is fully cleared again by INIT.
- len=0: single beat. len=2**LW-1 with LW=AW: every address visited once.

Optional Feature:
- Macro WRITE_VERIFY_EN.
- Defined:
  - After each WR beat, a VFY cycle: ram_we=0, same ram_a.
  - ram_do is compared with wdata; a mismatch sets err (sticky until reset).
  - Fill takes 2*(len+1) cycles.
- Undefined:
  - No VFY state; err tied 0.

Decomposition:
- Shared package ram_ctrl_pkg holds:
  - state enum (INIT, IDLE, WR, RD, VFY)
  - default AW/DW/LW localparams
- Natural sub-module: ram_burst_addr_gen.
  - Loads start address and length.
  - Steps the beat counter, outputs the wrapped address and the last-beat flag.
  - Shared by WR and RD.

Test Plan:
- Reset then wait -> exactly 32 cycles with ram_we=1 at addresses 0..31 and ram_di=0, then init_done=1 and req_ready=1. A single read at addr 7 returns rsp_data=0000.
- Fill-write addr=4, len=0, wdata=1010, then read addr=4 len=0 -> one rsp_valid pulse, rsp_data=1010, rsp_last=1, exactly 2 cycles after read accept.
- Fill addr=30, len=3, wdata=1100 (wraps 30,31,0,1), then read addr=29 len=4 -> rsp_data sequence 0000,1100,1100,1100,1100, rsp_last only on beat 5.
- req_valid held high during INIT and during a 6-beat read -> no acceptance until IDLE, request fields unchanged after acceptance, no lost or duplicated beats.
- Assert rst_n=0 for one cycle in the middle of the addr=0 len=31 fill with wdata=1111 -> rsp/err cleared, INIT restarts, a subsequent read of addr 0..31 returns all 0000.
- WRITE_VERIFY_EN with the RAM model forced to return 0110 for addr 9; fill addr=9 wdata=0011 -> err=1, and err stays 1 after later clean writes until reset.
